// File: rtl/pixel_strip_streamer.sv
// Streams image strips from a synchronous column memory to the CHIP pixel lanes.
// Each strip is framed as chip_rst, left pad, IMG_W body columns, and a right pad with load_end.
module pixel_strip_streamer #(
   parameter int IMG_W  = 100,
   parameter int PIX_W  = 5,
   parameter int ADDR_W = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [3:0]            num_strips,
   output logic                  mem_rd,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic [5*PIX_W-1:0]    mem_rdata,
   output logic [PIX_W-1:0]      pixel_in0,
   output logic [PIX_W-1:0]      pixel_in1,
   output logic [PIX_W-1:0]      pixel_in2,
   output logic [PIX_W-1:0]      pixel_in3,
   output logic [PIX_W-1:0]      pixel_in4,
   output logic                  load_end,
   output logic                  col_valid,
   output logic                  chip_rst,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [2:0] {S_IDLE, S_RST, S_PADL, S_BODY, S_PADR} state_t;

   localparam int CNT_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

   state_t               r_state;
   state_t               w_next;
   logic [CNT_W-1:0]     r_col;
   logic [CNT_W-1:0]     r_rd_left;
   logic [3:0]           r_strip;
   logic [3:0]           r_last;
   logic [ADDR_W-1:0]    r_base;
   logic [ADDR_W-1:0]    w_base_nxt;
   logic                 w_accept;
   logic                 w_last_strip;
   logic                 w_done_nxt;

   logic                 r_mem_rd;
   logic [ADDR_W-1:0]    r_mem_addr;
   logic [5*PIX_W-1:0]   r_lanes;
   logic                 r_load_end;
   logic                 r_col_valid;
   logic                 r_chip_rst;
   logic                 r_busy;
   logic                 r_done;

   // A start coinciding with done is dropped: the block only counts as idle once done has cleared.
   assign w_accept     = (r_state == S_IDLE) && start && !r_done;
   assign w_last_strip = (r_strip == r_last);

   always_comb begin
      w_next     = r_state;
      w_base_nxt = r_base;
      w_done_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next     = S_RST;
               w_base_nxt = '0;
            end
         end
         S_RST:  w_next = S_PADL;
         S_PADL: w_next = S_BODY;
         S_BODY: begin
            if (r_col == CNT_W'(IMG_W - 1)) w_next = S_PADR;
         end
         S_PADR: begin
            if (w_last_strip) begin
               w_next     = S_IDLE;
               w_done_nxt = 1'b1;
            end else begin
               w_next     = S_RST;
               w_base_nxt = r_base + ADDR_W'(IMG_W);
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_col       <= '0;
         r_rd_left   <= '0;
         r_strip     <= '0;
         r_last      <= '0;
         r_base      <= '0;
         r_mem_rd    <= 1'b0;
         r_mem_addr  <= '0;
         r_lanes     <= '0;
         r_load_end  <= 1'b0;
         r_col_valid <= 1'b0;
         r_chip_rst  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state <= w_next;
         r_base  <= w_base_nxt;
         r_col   <= (r_state == S_BODY) ? r_col + 1'b1 : '0;

         if (w_accept) begin
            r_strip <= '0;
            r_last  <= (num_strips == 4'd0) ? 4'd0 : num_strips - 4'd1;
         end else if ((r_state == S_PADR) && !w_last_strip) begin
            r_strip <= r_strip + 4'd1;
         end

         // The read burst starts with the RST cycle so the first body word lands right after PADL.
         if (w_next == S_RST) begin
            r_mem_rd   <= 1'b1;
            r_mem_addr <= w_base_nxt;
            r_rd_left  <= CNT_W'(IMG_W - 1);
         end else if (r_rd_left != '0) begin
            r_mem_rd   <= 1'b1;
            r_mem_addr <= r_mem_addr + 1'b1;
            r_rd_left  <= r_rd_left - 1'b1;
         end else begin
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
         end

         r_chip_rst  <= (w_next == S_RST);
         r_col_valid <= (w_next == S_PADL) || (w_next == S_BODY) || (w_next == S_PADR);
         r_load_end  <= (w_next == S_PADR);
         r_busy      <= (w_next != S_IDLE);
         r_done      <= w_done_nxt;
         r_lanes     <= (w_next == S_BODY) ? mem_rdata : '0;
      end
   end

   assign mem_rd    = r_mem_rd;
   assign mem_addr  = r_mem_addr;
   assign pixel_in0 = r_lanes[0*PIX_W +: PIX_W];
   assign pixel_in1 = r_lanes[1*PIX_W +: PIX_W];
   assign pixel_in2 = r_lanes[2*PIX_W +: PIX_W];
   assign pixel_in3 = r_lanes[3*PIX_W +: PIX_W];
   assign pixel_in4 = r_lanes[4*PIX_W +: PIX_W];
   assign load_end  = r_load_end;
   assign col_valid = r_col_valid;
   assign chip_rst  = r_chip_rst;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_pixel_strip_streamer.sv
// Scoreboard bench for pixel_strip_streamer with IMG_W=8, using a 12-bit and a 4-bit address instance.
module tb_pixel_strip_streamer;

   localparam int W = 8;
   localparam int P = W + 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  num = 4'd0;

   logic        rd_a, rd_b;
   logic [11:0] addr_a;
   logic [3:0]  addr_b;
   logic [24:0] rdata_a, rdata_b;
   logic [4:0]  pa0, pa1, pa2, pa3, pa4, pb0, pb1, pb2, pb3, pb4;
   logic        le_a, cv_a, cr_a, bz_a, dn_a;
   logic        le_b, cv_b, cr_b, bz_b, dn_b;

   int n_chk  = 0;
   int n_pass = 0;
   logic [42:0] q[$];

   always #5 clk = ~clk;

   pixel_strip_streamer #(.IMG_W(W), .PIX_W(5), .ADDR_W(12)) dut (
      .clk(clk), .reset(reset), .start(start), .num_strips(num),
      .mem_rd(rd_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
      .pixel_in0(pa0), .pixel_in1(pa1), .pixel_in2(pa2), .pixel_in3(pa3), .pixel_in4(pa4),
      .load_end(le_a), .col_valid(cv_a), .chip_rst(cr_a), .busy(bz_a), .done(dn_a));

   pixel_strip_streamer #(.IMG_W(W), .PIX_W(5), .ADDR_W(4)) dut_w (
      .clk(clk), .reset(reset), .start(start), .num_strips(num),
      .mem_rd(rd_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
      .pixel_in0(pb0), .pixel_in1(pb1), .pixel_in2(pb2), .pixel_in3(pb3), .pixel_in4(pb4),
      .load_end(le_b), .col_valid(cv_b), .chip_rst(cr_b), .busy(bz_b), .done(dn_b));

   // Memory word at address a is a on every lane; 31 marks a cycle with no read behind it.
   always_ff @(posedge clk) begin
      rdata_a <= rd_a ? {5{addr_a[4:0]}} : {5{5'd31}};
      rdata_b <= rd_b ? {5{1'b0, addr_b}} : {5{5'd31}};
   end

   task automatic check(input string tag, input logic [42:0] got, input logic [42:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [42:0] obs(input bit wide);
      if (wide)
         return {cr_b, rd_b, 8'd0, addr_b, cv_b, le_b, bz_b, dn_b, pb4, pb3, pb2, pb1, pb0};
      return {cr_a, rd_a, addr_a, cv_a, le_a, bz_a, dn_a, pa4, pa3, pa2, pa1, pa0};
   endfunction

   function automatic logic [42:0] exp_at(input int k, input int nstr, input bit wide);
      logic cr, rd, cv, le, bz, dn;
      logic [11:0] ad;
      logic [24:0] ln;
      logic [4:0]  pv;
      int s, o, a, m;
      cr = 0; rd = 0; cv = 0; le = 0; bz = 0; dn = 0; ad = '0; ln = '0;
      m = wide ? 16 : 4096;
      if (k >= 1 && k <= nstr * P) begin
         s  = (k - 1) / P;
         o  = (k - 1) % P;
         bz = 1;
         if (o == 0) cr = 1;
         if (o <= W - 1) begin
            rd = 1;
            a  = (s * W + o) % m;
            ad = 12'(a);
         end
         if (o >= 1 && o <= W + 2) cv = 1;
         if (o >= 2 && o <= W + 1) begin
            a  = (s * W + o - 2) % m;
            pv = 5'(a);
            ln = {5{pv}};
         end
         if (o == W + 2) le = 1;
      end else if (k == nstr * P + 1) begin
         dn = 1;
      end
      return {cr, rd, ad, cv, le, bz, dn, ln};
   endfunction

   // sa/sb: cycles carrying an extra start pulse; rc: cycle in which reset strikes (0 = none).
   task automatic run_frame(input int n, input int sa, input int sb, input int rc, input bit wide);
      int nstr, total, rdcnt;
      bit aborted;
      logic [42:0] got, exp;
      nstr    = (n == 0) ? 1 : n;
      total   = nstr * P + 4;
      rdcnt   = 0;
      aborted = 0;
      for (int k = 1; k <= total; k++) q.push_back(exp_at(k, nstr, wide));
      @(negedge clk);
      start = 1'b1;
      num   = 4'(n);
      for (int k = 1; k <= total; k++) begin
         @(negedge clk);
         start = (k == sa) || (k == sb);
         got = obs(wide);
         exp = q.pop_front();
         check($sformatf("n%0d_w%0d_cyc%0d", n, wide, k), got, exp);
         if (got[41]) rdcnt++;
         if (k == rc) begin
            #1 reset = 1'b1;
            #1 check("async_reset_outputs", obs(wide), '0);
            q.delete();
            @(negedge clk);
            reset = 1'b0;
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               check($sformatf("post_reset_idle%0d", i), obs(wide), '0);
            end
            aborted = 1;
            break;
         end
      end
      start = 1'b0;
      if (!aborted) check($sformatf("rd_count_n%0d", n), 43'(rdcnt), 43'(nstr * W));
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("reset_state", obs(0), '0);
      check("reset_state_w", obs(1), '0);
      reset = 1'b0;
      @(negedge clk);
      run_frame(1, 0, 0, 0, 0);
      run_frame(3, 0, 0, 0, 0);
      run_frame(0, 0, 0, 0, 0);
      run_frame(1, 5, 12, 0, 0);
      run_frame(1, 0, 0, 6, 0);
      run_frame(1, 0, 0, 0, 0);
      run_frame(3, 0, 0, 0, 1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
